// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
// Provides the arbiter state enum and an index-width helper.
package arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Searches req & ~excl starting at ptr, wrapping modulo N.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  excl,
  output logic          found,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  logic [N-1:0] cand;
  int           j;

  always_comb begin
    cand  = req & ~excl;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && cand[j]) begin
        found   = 1'b1;
        pick[j] = 1'b1;
        idx     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with bounded hold time.
// Grants are registered; a hold expiry hands off and pulses preempt.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_AGENTS = 4,
  parameter int MAX_HOLD   = 8,
  parameter int ID_W       = id_w(NUM_AGENTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_AGENTS-1:0] req,
  output logic [NUM_AGENTS-1:0] gnt,
  output logic                  gnt_valid,
  output logic [ID_W-1:0]       gnt_id,
  output logic                  preempt
);

  localparam int HCW = id_w(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HLAST =
    HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [ID_W-1:0] LAST_ID =
    ID_W'(NUM_AGENTS - 1);

  arb_state_e      state;
  logic [ID_W-1:0] ptr;
  logic [HCW-1:0]  hold_cnt;

  logic                  found;
  logic [NUM_AGENTS-1:0] pick;
  logic [ID_W-1:0]       idx;
  logic [ID_W-1:0]       nxt_ptr;
  logic                  owner_req;
  logic                  expire;

  // Excluding the current owner makes "found" mean "someone else waits".
  rr_pick #(
    .N  (NUM_AGENTS),
    .IW (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .excl  (gnt),
    .found (found),
    .pick  (pick),
    .idx   (idx)
  );

  assign nxt_ptr   = (idx == LAST_ID) ? '0 : idx + 1'b1;
  assign owner_req = |(req & gnt);
  assign expire    = (MAX_HOLD != 0) && (hold_cnt == HLAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      preempt   <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      preempt <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt       <= pick;
            gnt_valid <= 1'b1;
            gnt_id    <= idx;
            ptr       <= nxt_ptr;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req || expire) begin
            hold_cnt <= '0;
            if (found) begin
              gnt       <= pick;
              gnt_valid <= 1'b1;
              gnt_id    <= idx;
              ptr       <= nxt_ptr;
              preempt   <= owner_req;
            end else if (!owner_req) begin
              gnt       <= '0;
              gnt_valid <= 1'b0;
              gnt_id    <= '0;
              state     <= IDLE;
            end
          end else if (MAX_HOLD != 0) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
